alarm_seq_ctrl: RTL

Sequencer that owns the alarm comparator function. It arms and disarms the alarm, detects the entry into the alarm minute, and drives the buzzer for a bounded number of minutes. It also handles snooze (re-target N minutes later, with minute/hour wrap) and stop. It sits between the master time counters, the alarm-set registers and the buzzer/display.

---
 rtl/alarm_seq_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alarm_seq_ctrl.sv
// Alarm sequencer: arm/disarm, edge-triggered alarm-minute detect, bounded ring, snooze/stop.
// Optional macro ALARM_SNOOZE_LIMIT_EN caps snoozes per episode at MAX_SNOOZE.
module alarm_seq_ctrl #(
  parameter int unsigned SNOOZE_MINS = 9,
  parameter int unsigned RING_MINS   = 3,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] tmin,
  input  logic [6:0] thrs,
  input  logic [6:0] amin,
  input  logic [6:0] ahrs,
  input  logic       alarm_on,
  input  logic       snooze,
  input  logic       stop,
  input  logic       min_tick,
  output logic       buzz,
  output logic [1:0] state,
  output logic [6:0] snz_min,
  output logic [6:0] snz_hrs,
  output logic [3:0] snooze_cnt
);

  localparam logic [1:0] ST_OFF      = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_RINGING  = 2'd2;
  localparam logic [1:0] ST_SNOOZING = 2'd3;

  logic [1:0] state_q, state_d;
  logic       match_q, match_d;
  logic [3:0] ring_cnt_q, ring_cnt_d;
  logic [6:0] snz_min_q, snz_min_d;
  logic [6:0] snz_hrs_q, snz_hrs_d;
  logic [3:0] snooze_cnt_q, snooze_cnt_d;

  logic       trigger;
  logic       timeout;
  logic       snooze_ok;
  logic [7:0] snz_sum;
  logic [6:0] tgt_min;
  logic [6:0] tgt_hrs;
  logic [3:0] cnt_inc;

  always_comb begin
    // While snoozing the comparator watches the snooze target instead of the alarm-set time.
    if (state_q == ST_SNOOZING) begin
      match_d = (tmin == snz_min_q) && (thrs == snz_hrs_q);
    end else begin
      match_d = (tmin == amin) && (thrs == ahrs);
    end
    trigger = match_d && !match_q;
    timeout = min_tick && (ring_cnt_q == 4'(RING_MINS - 1));

    snz_sum = {1'b0, tmin} + 8'(SNOOZE_MINS);
    if (snz_sum >= 8'd60) begin
      tgt_min = 7'(snz_sum - 8'd60);
      tgt_hrs = (thrs == 7'd23) ? '0 : thrs + 7'd1;
    end else begin
      tgt_min = snz_sum[6:0];
      tgt_hrs = thrs;
    end

    cnt_inc = (snooze_cnt_q == 4'hF) ? snooze_cnt_q : snooze_cnt_q + 4'd1;

`ifdef ALARM_SNOOZE_LIMIT_EN
    snooze_ok = (snooze_cnt_q != 4'(MAX_SNOOZE));
`else
    // MAX_SNOOZE has no effect in this build; snoozing is always allowed.
    snooze_ok = 1'b1 || (MAX_SNOOZE == 0);
`endif

    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snz_min_d    = snz_min_q;
    snz_hrs_d    = snz_hrs_q;
    snooze_cnt_d = snooze_cnt_q;

    if (!alarm_on) begin
      state_d      = ST_OFF;
      snooze_cnt_d = '0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_ARMED;
        ST_ARMED: begin
          if (trigger) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
        ST_RINGING: begin
          if (stop || timeout) begin
            state_d      = ST_ARMED;
            snooze_cnt_d = '0;
          end else begin
            if (min_tick) ring_cnt_d = ring_cnt_q + 4'd1;
            if (snooze && snooze_ok) begin
              state_d      = ST_SNOOZING;
              snooze_cnt_d = cnt_inc;
              snz_min_d    = tgt_min;
              snz_hrs_d    = tgt_hrs;
            end
          end
        end
        ST_SNOOZING: begin
          if (stop) begin
            state_d      = ST_ARMED;
            snooze_cnt_d = '0;
          end else if (trigger) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      match_q      <= 1'b0;
      ring_cnt_q   <= '0;
      snz_min_q    <= '0;
      snz_hrs_q    <= '0;
      snooze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_min_q    <= snz_min_d;
      snz_hrs_q    <= snz_hrs_d;
      snooze_cnt_q <= snooze_cnt_d;
    end
  end

  assign buzz       = (state_q == ST_RINGING);
  assign state      = state_q;
  assign snz_min    = snz_min_q;
  assign snz_hrs    = snz_hrs_q;
  assign snooze_cnt = snooze_cnt_q;

endmodule
